// File: rtl/dmem_resp.sv
// -----------------------------------------------------------------------------
// dmem_resp
//
// Data-memory responder sitting behind the EX/MEM memory-request outputs.
// It holds a word-organised RAM and services byte, half-word and word
// loads/stores with a fixed, programmable latency. While an access is in
// flight it raises stall so the hazard logic can freeze the front of the
// pipeline. Load results are returned already extended and registered for
// MEM/WB capture.
//
// Parameters
//   DEPTH    number of 32-bit words in the RAM (power of two)
//   LATENCY  stall cycles per legal access (>= 1)
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous reset, active low
//   MemRead       load request
//   MemWrite      store request (wins when both requests are set)
//   DMType        funct3 access type: 000 b, 001 h, 010 w, 100 bu, 101 hu;
//                 remaining encodings behave as w
//   addr          byte address
//   wdata         store data
//   stall         access in progress, pipeline must hold
//   rdata         extended load data, held until the next completed load
//   rdata_valid   one-cycle pulse when rdata carries a completed load
//   misalign_err  misaligned request seen in IDLE (request is dropped)
// -----------------------------------------------------------------------------
module dmem_resp #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  DMType,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        misalign_err
);

    localparam int AW = $clog2(DEPTH);
    // Counter only needs to hold LATENCY-1.
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } size_e;

    // Undefined funct3 encodings fall through to a full-word access.
    function automatic size_e size_of(input logic [2:0] t);
        case (t)
            3'b000, 3'b100: size_of = SZ_B;
            3'b001, 3'b101: size_of = SZ_H;
            default:        size_of = SZ_W;
        endcase
    endfunction

    // -------------------------------------------------------------------------
    // State and latched request
    // -------------------------------------------------------------------------
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [2:0]    type_q;
    logic          store_q;

    logic          req;
    logic          misaligned;
    logic          accept;
    logic          stall_c;
    logic          misalign_c;

    // Only the byte offset and word index take part in the access; upper
    // address bits wrap the RAM and are intentionally dropped.
    logic          unused_addr_bits;
    assign unused_addr_bits = ^addr[31:AW+2];

    assign req = MemRead | MemWrite;

    always_comb begin
        misaligned = 1'b0;
        case (size_of(DMType))
            SZ_H:    misaligned = addr[0];
            SZ_W:    misaligned = (addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Next-state / output logic
    // -------------------------------------------------------------------------
    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stall_c    = 1'b0;
        misalign_c = 1'b0;
        accept     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (misaligned) begin
                        misalign_c = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        stall_c = 1'b1;
                        if (LATENCY == 1) begin
                            state_d = RESP;
                        end else begin
                            state_d = WAIT;
                            cnt_d   = CW'(LATENCY - 1);
                        end
                    end
                end
            end
            WAIT: begin
                stall_c = 1'b1;
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                // Pipeline advances now; a request here is never taken.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // stall must read 0 while reset is held even if a request is present.
    assign stall        = stall_c & rst;
    assign misalign_err = misalign_c;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            type_q  <= '0;
            store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= addr[AW+1:0];
                wdata_q <= wdata;
                type_q  <= DMType;
                store_q <= MemWrite;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Access operands
    // -------------------------------------------------------------------------
    // With LATENCY=1 the RAM is touched on the accept edge itself, before the
    // latched copies exist, so IDLE uses the live request.
    logic [AW+1:0] acc_addr;
    logic [31:0]   acc_wdata;
    logic [2:0]    acc_type;
    logic          acc_store;

    always_comb begin
        if (state_q == IDLE) begin
            acc_addr  = addr[AW+1:0];
            acc_wdata = wdata;
            acc_type  = DMType;
            acc_store = MemWrite;
        end else begin
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_type  = type_q;
            acc_store = store_q;
        end
    end

    // The edge leaving the last stall cycle is the one entering RESP.
    logic fire;
    assign fire = (state_d == RESP);

    logic [AW-1:0] idx;
    assign idx = acc_addr[AW+1:2];

    // -------------------------------------------------------------------------
    // RAM with byte-lane write enables
    // -------------------------------------------------------------------------
    logic [31:0] mem_q [DEPTH];
    logic [3:0]  be;
    logic [31:0] wlane;
    logic        ram_we;

    always_comb begin
        be    = 4'b0000;
        wlane = acc_wdata;
        case (size_of(acc_type))
            SZ_B: begin
                be             = 4'b0001 << acc_addr[1:0];
                wlane          = {4{acc_wdata[7:0]}};
            end
            SZ_H: begin
                be             = acc_addr[1] ? 4'b1100 : 4'b0011;
                wlane          = {2{acc_wdata[15:0]}};
            end
            default: begin
                be             = 4'b1111;
                wlane          = acc_wdata;
            end
        endcase
    end

    // A store interrupted by reset must never reach the array.
    assign ram_we = fire & acc_store & rst;

    // NOTE: the RAM array has no reset; contents survive rst and only the
    // control path is cleared.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[idx][8*i +: 8] <= wlane[8*i +: 8];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Load extraction and extension
    // -------------------------------------------------------------------------
    logic [31:0] rd_word;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_ext;
    logic        zero_ext;

    assign rd_word  = mem_q[idx];
    assign sel_byte = rd_word[{acc_addr[1:0], 3'b000} +: 8];
    assign sel_half = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];
    // funct3[2] selects the unsigned variants (only meaningful for b/h).
    assign zero_ext = acc_type[2];

    always_comb begin
        case (size_of(acc_type))
            SZ_B:    load_ext = zero_ext ? {24'b0, sel_byte}
                                         : {{24{sel_byte[7]}}, sel_byte};
            SZ_H:    load_ext = zero_ext ? {16'b0, sel_half}
                                         : {{16{sel_half[15]}}, sel_half};
            default: load_ext = rd_word;
        endcase
    end

    logic [31:0] rdata_q;
    logic        rdata_valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            // Valid rises on RESP entry; RESP always returns to IDLE, so the
            // pulse lasts exactly one cycle.
            rdata_valid_q <= fire & ~acc_store;
            if (fire && !acc_store) begin
                rdata_q <= load_ext;
            end
        end
    end

    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;

endmodule

// File: tb/tb_dmem_resp.sv
// -----------------------------------------------------------------------------
// tb_dmem_resp
//
// Three dmem_resp instances (LATENCY 1, 2, 4) driven one at a time. A
// word-array reference model computes load results and byte-merged stores
// with plain arithmetic; stall length, RESP gap, valid pulse, misalignment
// rejection and mid-access reset are all checked against it.
// -----------------------------------------------------------------------------
module tb_dmem_resp;

    localparam int DEPTH = 64;
    localparam int NDUT  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NDUT-1:0]       rst_v;
    logic [NDUT-1:0]       rd_v;
    logic [NDUT-1:0]       wr_v;
    logic [NDUT-1:0][2:0]  type_v;
    logic [NDUT-1:0][31:0] addr_v;
    logic [NDUT-1:0][31:0] wdata_v;
    logic [NDUT-1:0]       stall_v;
    logic [NDUT-1:0][31:0] rdata_v;
    logic [NDUT-1:0]       valid_v;
    logic [NDUT-1:0]       mis_v;

    dmem_resp #(.DEPTH(DEPTH), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst_v[0]), .MemRead(rd_v[0]), .MemWrite(wr_v[0]),
        .DMType(type_v[0]), .addr(addr_v[0]), .wdata(wdata_v[0]),
        .stall(stall_v[0]), .rdata(rdata_v[0]), .rdata_valid(valid_v[0]),
        .misalign_err(mis_v[0])
    );

    dmem_resp #(.DEPTH(DEPTH), .LATENCY(2)) u_dut_l2 (
        .clk(clk), .rst(rst_v[1]), .MemRead(rd_v[1]), .MemWrite(wr_v[1]),
        .DMType(type_v[1]), .addr(addr_v[1]), .wdata(wdata_v[1]),
        .stall(stall_v[1]), .rdata(rdata_v[1]), .rdata_valid(valid_v[1]),
        .misalign_err(mis_v[1])
    );

    dmem_resp #(.DEPTH(DEPTH), .LATENCY(4)) u_dut_l4 (
        .clk(clk), .rst(rst_v[2]), .MemRead(rd_v[2]), .MemWrite(wr_v[2]),
        .DMType(type_v[2]), .addr(addr_v[2]), .wdata(wdata_v[2]),
        .stall(stall_v[2]), .rdata(rdata_v[2]), .rdata_valid(valid_v[2]),
        .misalign_err(mis_v[2])
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    logic [31:0] model_mem   [NDUT][DEPTH];
    logic [31:0] model_rdata [NDUT];

    function automatic int lat_of(input int k);
        case (k)
            0:       return 1;
            1:       return 2;
            default: return 4;
        endcase
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic bit is_half(input logic [2:0] t);
        return (t == 3'b001) || (t == 3'b101);
    endfunction

    function automatic bit is_byte(input logic [2:0] t);
        return (t == 3'b000) || (t == 3'b100);
    endfunction

    function automatic bit is_misaligned(input logic [2:0] t, input logic [31:0] a);
        if (is_half(t)) return a[0];
        if (is_byte(t)) return 1'b0;
        return (a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] load_value(input logic [31:0] w, input logic [2:0] t,
                                               input logic [31:0] a);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * int'(a[1:0]))) & 32'hFF;
        h = (w >> (16 * int'(a[1]))) & 32'hFFFF;
        case (t)
            3'b000:  return (b >= 128) ? b - 32'd256 : b;
            3'b100:  return b;
            3'b001:  return (h >= 32768) ? h - 32'd65536 : h;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [2:0] t,
                                                input logic [31:0] a, input logic [31:0] d);
        logic [31:0] mask;
        int          sh;
        if (is_byte(t)) begin
            sh   = 8 * int'(a[1:0]);
            mask = 32'hFF << sh;
        end else if (is_half(t)) begin
            sh   = 16 * int'(a[1]);
            mask = 32'hFFFF << sh;
        end else begin
            sh   = 0;
            mask = 32'hFFFF_FFFF;
        end
        return (w & ~mask) | ((d << sh) & mask);
    endfunction

    // -------------------------------------------------------------------------
    // One request on DUT k, started at a negedge while the DUT is in IDLE.
    // Returns at the negedge of the following IDLE cycle with requests
    // dropped, so a further call there is back-to-back.
    // -------------------------------------------------------------------------
    task automatic access(input int k, input bit rd, input bit wr, input logic [2:0] t,
                          input logic [31:0] a, input logic [31:0] d, input string tag);
        bit          mis;
        int          n;
        int          w;
        logic [31:0] exp;
        mis        = is_misaligned(t, a);
        w          = word_of(a);
        rd_v[k]    = rd;
        wr_v[k]    = wr;
        type_v[k]  = t;
        addr_v[k]  = a;
        wdata_v[k] = d;
        #1;
        check({tag, " misalign_err"}, 32'(mis_v[k]), 32'(mis));
        if (mis) begin
            check({tag, " stall on misaligned"}, 32'(stall_v[k]), 32'd0);
            @(negedge clk);
            check({tag, " still idle"}, 32'(stall_v[k]), 32'd0);
            check({tag, " no valid"}, 32'(valid_v[k]), 32'd0);
            check({tag, " rdata kept"}, rdata_v[k], model_rdata[k]);
        end else begin
            // Count stall cycles; inputs are scrambled after acceptance to
            // prove the latched copies are the ones used.
            n = 0;
            while (stall_v[k] === 1'b1 && n < 16) begin
                n++;
                @(negedge clk);
                addr_v[k]  = $urandom;
                wdata_v[k] = $urandom;
                type_v[k]  = 3'($urandom_range(0, 7));
                #1;
            end
            check({tag, " stall cycles"}, 32'(n), 32'(lat_of(k)));
            check({tag, " no misalign in RESP"}, 32'(mis_v[k]), 32'd0);
            if (wr) begin
                model_mem[k][w] = store_merge(model_mem[k][w], t, a, d);
                check({tag, " no valid on store"}, 32'(valid_v[k]), 32'd0);
            end else begin
                exp            = load_value(model_mem[k][w], t, a);
                model_rdata[k] = exp;
                check({tag, " valid in RESP"}, 32'(valid_v[k]), 32'd1);
                check({tag, " rdata"}, rdata_v[k], exp);
            end
        end
        @(negedge clk);
        rd_v[k] = 1'b0;
        wr_v[k] = 1'b0;
        if (!mis) begin
            check({tag, " valid drops"}, 32'(valid_v[k]), 32'd0);
        end
    endtask

    task automatic random_phase(input int k, input int count);
        int          op;
        logic [2:0]  t;
        logic [31:0] a;
        for (int i = 0; i < count; i++) begin
            op = $urandom_range(0, 3);
            t  = 3'($urandom_range(0, 7));
            a  = $urandom_range(0, DEPTH * 8 - 1);
            // op 3 sets both requests; the store must win.
            access(k, (op <= 1) || (op == 3), op >= 2, t, a, $urandom, "rand");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_v   = '0;
        rd_v    = '0;
        wr_v    = '0;
        type_v  = '0;
        addr_v  = '0;
        wdata_v = '0;
        for (int k = 0; k < NDUT; k++) model_rdata[k] = 32'd0;

        repeat (3) @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            check("reset stall", 32'(stall_v[k]), 32'd0);
            check("reset rdata", rdata_v[k], 32'd0);
            check("reset valid", 32'(valid_v[k]), 32'd0);
        end
        rst_v = '1;
        @(negedge clk);

        // Give every RAM word a known value.
        for (int k = 0; k < NDUT; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                access(k, 1'b0, 1'b1, 3'b010, 32'(i * 4), $urandom, "init sw");
            end
        end

        // Directed sequence on the LATENCY=2 instance.
        access(1, 0, 1, 3'b010, 32'h10, 32'hDEADBEEF, "sw 0x10");
        access(1, 1, 0, 3'b010, 32'h10, 32'h0, "lw 0x10");
        check("lw 0x10 literal", rdata_v[1], 32'hDEADBEEF);
        access(1, 1, 0, 3'b000, 32'h13, 32'h0, "lb 0x13");
        check("lb 0x13 literal", rdata_v[1], 32'hFFFFFFDE);
        access(1, 1, 0, 3'b100, 32'h13, 32'h0, "lbu 0x13");
        check("lbu 0x13 literal", rdata_v[1], 32'h000000DE);
        access(1, 1, 0, 3'b001, 32'h10, 32'h0, "lh 0x10");
        check("lh 0x10 literal", rdata_v[1], 32'hFFFFBEEF);
        access(1, 1, 0, 3'b101, 32'h12, 32'h0, "lhu 0x12");
        check("lhu 0x12 literal", rdata_v[1], 32'h0000DEAD);
        access(1, 0, 1, 3'b000, 32'h11, 32'h55, "sb 0x11");
        access(1, 1, 0, 3'b010, 32'h10, 32'h0, "lw after sb");
        check("lw after sb literal", rdata_v[1], 32'hDEAD55EF);
        access(1, 0, 1, 3'b001, 32'h12, 32'h1234, "sh 0x12");
        access(1, 1, 0, 3'b010, 32'h10, 32'h0, "lw after sh");
        check("lw after sh literal", rdata_v[1], 32'h123455EF);

        access(1, 1, 0, 3'b010, 32'h11, 32'h0, "lw 0x11 misaligned");
        access(1, 1, 0, 3'b001, 32'h13, 32'h0, "lh 0x13 misaligned");
        access(1, 0, 1, 3'b010, 32'h12, 32'hFFFFFFFF, "sw 0x12 misaligned");
        access(1, 1, 0, 3'b010, 32'h10, 32'h0, "lw after misaligned sw");
        check("word unchanged literal", rdata_v[1], 32'h123455EF);

        // Address wrap: 0x110 aliases 0x10 with 64 words.
        access(1, 0, 1, 3'b010, 32'h110, 32'hCAFEF00D, "sw wrap");
        access(1, 1, 0, 3'b010, 32'h10, 32'h0, "lw wrap");
        check("wrap literal", rdata_v[1], 32'hCAFEF00D);

        // Reset while a store sits in WAIT.
        access(1, 0, 1, 3'b010, 32'h20, 32'h11223344, "sw 0x20");
        access(1, 1, 0, 3'b010, 32'h20, 32'h0, "lw 0x20 pre");
        rd_v[1]    = 1'b0;
        wr_v[1]    = 1'b1;
        type_v[1]  = 3'b010;
        addr_v[1]  = 32'h20;
        wdata_v[1] = 32'hA5A5A5A5;
        @(negedge clk);
        check("in WAIT stall", 32'(stall_v[1]), 32'd1);
        rst_v[1] = 1'b0;
        #1;
        check("mid-access reset stall", 32'(stall_v[1]), 32'd0);
        check("mid-access reset rdata", rdata_v[1], 32'd0);
        check("mid-access reset valid", 32'(valid_v[1]), 32'd0);
        model_rdata[1] = 32'd0;
        @(negedge clk);
        wr_v[1] = 1'b0;
        @(negedge clk);
        rst_v[1] = 1'b1;
        @(negedge clk);
        access(1, 1, 0, 3'b010, 32'h20, 32'h0, "lw 0x20 post reset");
        check("aborted store literal", rdata_v[1], 32'h11223344);

        // Back-to-back loads on the LATENCY=1 and LATENCY=4 instances.
        for (int k = 0; k < NDUT; k += 2) begin
            for (int i = 0; i < 4; i++) begin
                access(k, 1, 0, 3'b010, 32'(i * 4), 32'h0, "b2b lw");
            end
        end

        for (int k = 0; k < NDUT; k++) begin
            random_phase(k, 80);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
